// File: rtl/hkspi_master.sv
// -----------------------------------------------------------------------------
// hkspi_master
//
// SPI master (mode 0) for the housekeeping SPI slave. One request produces one
// stream transaction: command byte {rw, 6'b0}, address byte, then `len` data
// bytes. Write data is pulled through a valid/ready handshake; read data is
// returned as one-cycle byte pulses.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   start                 request strobe, sampled only while busy = 0
//   rw[1:0]               command select (rw[1] = write, rw[0] = read)
//   addr[7:0], len[3:0]   register address and data byte count, latched on start
//   wdata, wdata_valid    write data offer
//   wdata_ready           write byte accepted this cycle
//   rdata, rdata_valid    received data byte and its one-cycle strobe
//   busy, done            transaction in progress / end-of-transaction pulse
//   sck, csb, sdi, sdo    SPI pins
// -----------------------------------------------------------------------------
module hkspi_master #(
  parameter int CLK_DIV = 2,  // SCK half-period in clock cycles (>= 1)
  parameter int CSB_GAP = 2   // CSB setup / hold / min-high in clock cycles (>= 1)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] rw,
  input  logic [7:0] addr,
  input  logic [3:0] len,
  input  logic [7:0] wdata,
  input  logic       wdata_valid,
  output logic       wdata_ready,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       csb,
  output logic       sdi,
  input  logic       sdo
);

  localparam int CNT_MAX = (CLK_DIV > CSB_GAP) ? CLK_DIV : CSB_GAP;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CSB_GAP - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;     // clock-cycle counter within a phase
  logic [2:0]    bit_q, bit_d;     // bit index within the current byte
  logic [4:0]    byte_q, byte_d;   // index of the byte on the wire (0 = command)
  logic [7:0]    tx_q, tx_d;       // tx_q[7] is the bit currently on sdi
  logic [6:0]    rx_q, rx_d;       // first seven bits of the incoming byte
  logic [1:0]    rw_q, rw_d;
  logic [7:0]    addr_q, addr_d;
  logic [3:0]    len_q, len_d;
  logic          sck_q, sck_d;
  logic          csb_q, csb_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rdata_valid_q, rdata_valid_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    byte_d        = byte_q;
    tx_d          = tx_q;
    rx_d          = rx_q;
    rw_d          = rw_q;
    addr_d        = addr_q;
    len_d         = len_q;
    sck_d         = sck_q;
    csb_d         = csb_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          rw_d    = rw;
          addr_d  = addr;
          len_d   = len;
          tx_d    = {rw, 6'b0};
          csb_d   = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end

      S_SETUP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SHIFT: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (!sck_q) begin
            // Rising edge: sample sdo.
            sck_d = 1'b1;
            rx_d  = {rx_q[5:0], sdo};
            if (bit_q == 3'd7 && rw_q[0] && byte_q >= 5'd2) begin
              rdata_d       = {rx_q, sdo};
              rdata_valid_d = 1'b1;
            end
          end else begin
            // Falling edge: advance sdi, or close the byte.
            sck_d = 1'b0;
            if (bit_q != 3'd7) begin
              bit_d = bit_q + 1'b1;
              tx_d  = {tx_q[6:0], 1'b0};
            end else begin
              bit_d  = '0;
              byte_d = byte_q + 5'd1;
              if (byte_q == 5'd0) begin
                tx_d = addr_q;
              end else if (byte_q <= {1'b0, len_q}) begin
                // Another data byte follows; sdi keeps the last bit while
                // a write byte is fetched.
                if (rw_q[1]) state_d = S_LOAD;
                else         tx_d    = 8'h00;
              end else begin
                state_d = S_HOLD;
              end
            end
          end
        end
      end

      S_LOAD: begin
        if (wdata_valid) begin
          tx_d    = wdata;
          state_d = S_SHIFT;
          cnt_d   = '0;
        end
      end

      S_HOLD: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
          csb_d   = 1'b1;
          tx_d    = 8'h00;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        csb_d   = 1'b1;
        sck_d   = 1'b0;
        tx_d    = 8'h00;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values computed before this edge, independent of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      byte_q        <= '0;
      tx_q          <= '0;
      rx_q          <= '0;
      rw_q          <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      sck_q         <= 1'b0;
      csb_q         <= 1'b1;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      byte_q        <= byte_d;
      tx_q          <= tx_d;
      rx_q          <= rx_d;
      rw_q          <= rw_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      sck_q         <= sck_d;
      csb_q         <= csb_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  assign sck         = sck_q;
  assign csb         = csb_q;
  assign sdi         = tx_q[7];
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign wdata_ready = (state_q == S_LOAD);
  assign done        = (state_q == S_GAP) && (cnt_q == GAP_LAST);

endmodule

// File: tb/tb_hkspi_master.sv
// -----------------------------------------------------------------------------
// tb_hkspi_master
//
// Directed bench for hkspi_master (CLK_DIV = 2, CSB_GAP = 2). A monitor acts
// as the housekeeping slave: it records the bytes seen on sdi, answers on sdo
// with a programmed byte list after the command and address bytes, and counts
// sck rises, rdata_valid pulses, wdata_ready cycles and done pulses.
// -----------------------------------------------------------------------------
module tb_hkspi_master;

  logic       clock;
  logic       reset;
  logic       start;
  logic [1:0] rw;
  logic [7:0] addr;
  logic [3:0] len;
  logic [7:0] wdata;
  logic       wdata_valid;
  logic       wdata_ready;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       busy;
  logic       done;
  logic       sck;
  logic       csb;
  logic       sdi;
  logic       sdo;

  hkspi_master #(.CLK_DIV(2), .CSB_GAP(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .rw          (rw),
    .addr        (addr),
    .len         (len),
    .wdata       (wdata),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .busy        (busy),
    .done        (done),
    .sck         (sck),
    .csb         (csb),
    .sdi         (sdi),
    .sdo         (sdo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tcyc = 0;
  always @(posedge clock) tcyc <= tcyc + 1;

  // Stimulus-owned controls for the monitor.
  logic       mon_clr  = 1'b0;
  int         exp_bits = 0;
  logic [7:0] resp [16];

  // Monitor-owned observations.
  logic [7:0] mosi  [17];
  logic [7:0] rvals [16];
  int rise_cnt, rv_cnt, ready_cnt, done_cnt, csb_glitch, first_rise_t;
  logic sck_prev = 1'b0;

  initial sdo = 1'b0;

  // Slave model and monitor, evaluated 1 unit after each falling clock edge.
  always @(negedge clock) begin
    #1;
    if (mon_clr) begin
      rise_cnt = 0; rv_cnt = 0; ready_cnt = 0; done_cnt = 0;
      csb_glitch = 0; first_rise_t = -1;
      for (int i = 0; i < 17; i++) mosi[i] = 8'h00;
      for (int i = 0; i < 16; i++) rvals[i] = 8'h00;
    end else begin
      if (sck === 1'b1 && sck_prev === 1'b0) begin
        if (rise_cnt / 8 < 17) mosi[rise_cnt / 8][7 - (rise_cnt % 8)] = sdi;
        if (rise_cnt == 0) first_rise_t = tcyc;
        rise_cnt++;
      end
      if (rdata_valid === 1'b1) begin
        if (rv_cnt < 16) rvals[rv_cnt] = rdata;
        rv_cnt++;
      end
      if (wdata_ready === 1'b1) ready_cnt++;
      if (done === 1'b1) done_cnt++;
      if (csb !== 1'b0 && rise_cnt > 0 && rise_cnt < exp_bits) csb_glitch++;
    end
    sck_prev = sck;
    // Next bit the slave presents: data bytes follow the 16 header bits.
    if (rise_cnt >= 16 && (rise_cnt - 16) / 8 < 16)
      sdo = resp[(rise_cnt - 16) / 8][7 - (rise_cnt % 8)];
    else
      sdo = 1'b0;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge clock);
    mon_clr = 1'b1;
    @(negedge clock);
    mon_clr = 1'b0;
  endtask

  // Issues one request and waits for done. dur counts cycles from the start
  // cycle through the done cycle, inclusive.
  task automatic do_txn(input logic [1:0] r, input logic [7:0] a, input logic [3:0] l,
                        input int budget, output int dur, output int t0);
    int cyc;
    clear_mon();
    start = 1'b1; rw = r; addr = a; len = l;
    t0 = tcyc;
    @(negedge clock);
    start = 1'b0;
    check("busy_cycle1", busy, 1);
    check("csb_cycle1", csb, 0);
    cyc = 1;
    while (done !== 1'b1 && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
    check("done_within_budget", done, 1);
    dur = cyc + 1;
    @(negedge clock);
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
  endtask

  int dur, t0, cyc, bad;
  logic [7:0] dump [15] = '{8'h00, 8'h04, 8'h56, 8'h11, 8'h02, 8'h03, 8'h7F, 8'h80,
                            8'h01, 8'hFF, 8'h00, 8'hA5, 8'h5A, 8'h3C, 8'hC3};

  initial begin
    reset = 1'b1; start = 1'b0; rw = 2'b00; addr = 8'h00; len = 4'd0;
    wdata = 8'h00; wdata_valid = 1'b0;
    for (int i = 0; i < 16; i++) resp[i] = 8'h00;
    #2;
    // Reset values
    check("rst_csb", csb, 1);
    check("rst_sck", sck, 0);
    check("rst_sdi", sdi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata_valid", rdata_valid, 0);
    check("rst_wdata_ready", wdata_ready, 0);
    check("rst_rdata", rdata, 8'h00);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Product ID read
    resp[0] = 8'h11; exp_bits = 24;
    do_txn(2'b01, 8'h03, 4'd1, 500, dur, t0);
    check("id_cmd", mosi[0], 8'h40);
    check("id_addr", mosi[1], 8'h03);
    check("id_data", mosi[2], 8'h00);
    check("id_rv_count", rv_cnt, 1);
    check("id_rdata", rvals[0], 8'h11);
    check("id_duration", dur, 103);
    check("id_first_rise", first_rise_t - t0, 5);
    check("id_sck_rises", rise_cnt, 24);
    check("id_no_ready", ready_cnt, 0);
    check("id_csb_low", csb_glitch, 0);

    // Write stream, data always valid
    wdata = 8'h01; wdata_valid = 1'b1;
    do_txn(2'b10, 8'h0b, 4'd1, 500, dur, t0);
    check("wr_cmd", mosi[0], 8'h80);
    check("wr_addr", mosi[1], 8'h0b);
    check("wr_data", mosi[2], 8'h01);
    check("wr_ready_cycles", ready_cnt, 1);
    check("wr_rv_count", rv_cnt, 0);
    check("wr_duration", dur, 104);
    wdata_valid = 1'b0;

    // Streaming register dump, 15 bytes
    for (int i = 0; i < 15; i++) resp[i] = dump[i];
    exp_bits = 17 * 8;
    do_txn(2'b01, 8'h00, 4'd15, 2000, dur, t0);
    check("dump_cmd", mosi[0], 8'h40);
    check("dump_rv_count", rv_cnt, 15);
    bad = 0;
    for (int i = 0; i < 15; i++) if (rvals[i] !== dump[i]) bad++;
    check("dump_values", bad, 0);
    check("dump_csb_low", csb_glitch, 0);
    check("dump_duration", dur, 551);

    // Read/write with a 10-cycle stall at the second data byte
    resp[0] = 8'h9A; resp[1] = 8'h5E; exp_bits = 32;
    wdata = 8'hA5; wdata_valid = 1'b1;
    clear_mon();
    start = 1'b1; rw = 2'b11; addr = 8'h20; len = 4'd2;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (wdata_ready !== 1'b1 && cyc < 400) begin @(negedge clock); cyc++; end
    check("stall_first_ready", wdata_ready, 1);
    @(posedge clock);
    #1;
    wdata = 8'h3C; wdata_valid = 1'b0;
    cyc = 0;
    while (wdata_ready !== 1'b1 && cyc < 400) begin @(negedge clock); cyc++; end
    check("stall_second_ready", wdata_ready, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (sck !== 1'b0 || csb !== 1'b0) bad++;
      @(negedge clock);
    end
    check("stall_pins_held", bad, 0);
    wdata_valid = 1'b1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin @(negedge clock); cyc++; end
    check("stall_done", done, 1);
    @(negedge clock);
    wdata_valid = 1'b0;
    check("stall_cmd", mosi[0], 8'hC0);
    check("stall_addr", mosi[1], 8'h20);
    check("stall_data0", mosi[2], 8'hA5);
    check("stall_data1", mosi[3], 8'h3C);
    check("stall_ready_cycles", ready_cnt, 12);
    check("stall_rv_count", rv_cnt, 2);
    check("stall_rdata0", rvals[0], 8'h9A);
    check("stall_rdata1", rvals[1], 8'h5E);
    check("stall_csb_low", csb_glitch, 0);

    // len = 0: header bytes only
    exp_bits = 16;
    do_txn(2'b01, 8'h07, 4'd0, 500, dur, t0);
    check("len0_sck_rises", rise_cnt, 16);
    check("len0_rv_count", rv_cnt, 0);
    check("len0_done_count", done_cnt, 1);
    check("len0_duration", dur, 71);

    // start while busy is ignored
    clear_mon();
    start = 1'b1; rw = 2'b01; addr = 8'h05; len = 4'd0;
    @(negedge clock);
    start = 1'b0;
    repeat (20) @(negedge clock);
    start = 1'b1; rw = 2'b10; len = 4'd3;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin @(negedge clock); cyc++; end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (busy !== 1'b0) bad++;
    end
    check("busy_start_no_restart", bad, 0);
    check("busy_start_done_count", done_cnt, 1);
    check("busy_start_sck_rises", rise_cnt, 16);
    check("busy_start_addr", mosi[1], 8'h05);
    check("busy_start_no_ready", ready_cnt, 0);

    // Reset in the middle of the address byte
    resp[0] = 8'h11; exp_bits = 24;
    clear_mon();
    start = 1'b1; rw = 2'b01; addr = 8'h03; len = 4'd1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (rise_cnt < 12 && cyc < 400) begin @(negedge clock); cyc++; end
    check("abort_reached_addr", rise_cnt >= 12, 1);
    reset = 1'b1;
    #1;
    check("abort_csb", csb, 1);
    check("abort_sck", sck, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_rdata", rdata, 8'h00);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("abort_no_done", done_cnt, 0);
    do_txn(2'b01, 8'h03, 4'd1, 500, dur, t0);
    check("rerun_cmd", mosi[0], 8'h40);
    check("rerun_addr", mosi[1], 8'h03);
    check("rerun_rdata", rvals[0], 8'h11);
    check("rerun_rv_count", rv_cnt, 1);
    check("rerun_duration", dur, 103);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hkspi_master.md
# hkspi_master

Synthesizable SPI master that drives the housekeeping SPI slave from on-chip or test-harness logic, replacing hand-timed pin toggling of SCK/CSB/SDI. It issues one housekeeping stream transaction per request: command byte, address byte, then `len` data bytes, with write data taken through a valid/ready handshake and read data returned as byte pulses. It sits directly upstream of the housekeeping SPI, and its `sck`/`csb`/`sdi`/`sdo` pins connect to the `mprj_io[4]`/`[3]`/`[2]`/`[1]` path.

## Interface
- `CLK_DIV`, 2, SCK half-period in `clock` cycles (≥1)
- `CSB_GAP`, 2, CSB setup, hold and minimum-high time in `clock` cycles (≥1)

- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request strobe; sampled only while `busy`=0
- `rw`  in  2  command select; command byte = {rw, 6'b0}: 2'b01 read stream (0x40), 2'b10 write stream (0x80), 2'b11 read/write (0xC0), 2'b00 sends 0x00
- `addr`  in  8  register address, latched on start
- `len`  in  4  number of data bytes (0–15), latched on start
- `wdata`  in  8  write data byte
- `wdata_valid`  in  1  write data offered
- `wdata_ready`  out  1  master accepts `wdata` this cycle
- `rdata`  out  8  last received data byte
- `rdata_valid`  out  1  one-cycle pulse per received data byte
- `busy`  out  1  transaction in progress
- `done`  out  1  one-cycle pulse at transaction end
- `sck`  out  1  SPI clock, idle low (mode 0)
- `csb`  out  1  chip select, active low
- `sdi`  out  1  master-out data, MSB first
- `sdo`  in  1  master-in data

## Operation
- Reset values: `csb`=1, `sck`=0, `sdi`=0, `busy`=0, `done`=0, `rdata_valid`=0, `wdata_ready`=0, `rdata`=8'h00. State is IDLE.
- States:
  - IDLE → SETUP on `start`; latches rw/addr/len and loads the shift register with the command byte.
  - SETUP: `csb`=0, `sdi`=bit 7, lasts CSB_GAP cycles → SHIFT.
  - SHIFT: 8 bits per byte. Each bit is `sck` low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - Byte order: command, address, then data bytes.
  - At each byte boundary:
    - A following write data byte (rw[1]=1) → LOAD.
    - A following data byte with rw[1]=0 → SHIFT with 8'h00.
    - No bytes remaining → HOLD.
  - LOAD: `sck`=0, `wdata_ready`=1. Stays until `wdata_valid`, lasting at least 1 cycle. Captures `wdata` → SHIFT.
  - HOLD: `sck`=0, `csb`=0 for CSB_GAP cycles → GAP.
  - GAP: `csb`=1 for CSB_GAP cycles. `done` pulses on the last GAP cycle → IDLE.
- `sdi` changes only on the clock edge that drives `sck` 1→0, or when a new byte is loaded while `sck`=0. It holds the last bit through HOLD, then returns to 0 in GAP.
- `sdo` is sampled on the clock edge that drives `sck` 0→1 and shifted in MSB first.
- Read data (rw[0]=1, data bytes only): `rdata` updates and `rdata_valid` pulses on the cycle after the 8th sample. Nothing is returned for the command and address bytes, and `rdata_valid` never pulses when rw[0]=0.
- `len`=0: only the command and address bytes are sent, with no LOAD and no `rdata_valid`.
- `start` while `busy`=1 is ignored and not queued.
- `reset` mid-transaction aborts immediately to the reset values, with no `done` pulse.

## Timing
- `start` at cycle 0 → `busy`=1 and `csb`=0 at cycle 1.
- First `sck` rise at cycle 1+CSB_GAP+CLK_DIV.
- Read-only transaction duration (start to `done`): 1 + CSB_GAP + (2+len)·16·CLK_DIV + 2·CSB_GAP cycles.
- Write modes add the LOAD cycles: one per data byte when `wdata_valid` is already high, plus any stall cycles.
- `busy` falls the cycle after `done`, and `start` may be accepted in that same cycle.
- Clock counters are $clog2(max(CLK_DIV,CSB_GAP))+1 bits. The bit counter is 3 bits and the byte counter is 5 bits, with no wrap (max 17 bytes).

## Test plan
- Product ID read: CLK_DIV=2, rw=01, addr=0x03, len=1, slave model returns 0x11 → `sdi` shifts 0x40, 0x03, 0x00; exactly one `rdata_valid` with `rdata`=0x11; `done` at cycle 1+2+48·2+4=103.
- Write stream: rw=10, addr=0x0b, len=1, `wdata`=0x01 always valid → `sdi` bytes 0x80, 0x0b, 0x01; one `wdata_ready` cycle; `rdata_valid` never asserts.
- Streaming register dump: rw=01, addr=0x00, len=15, model returns 0x00, 0x04, 0x56, 0x11, … → 15 `rdata_valid` pulses with values in order; `csb` low continuously from first bit to last.
- Write stall: rw=11, len=2, `wdata_valid` low for 10 cycles at the second data byte → `sck` held low and `csb` held low for the stall; data resumes intact; the read bytes still return.
- Boundaries: `len`=0 → 16 `sck` pulses then `done`. `start` pulsed while busy → ignored, no second transaction. `reset` asserted mid-address byte → `csb`=1, `sck`=0 immediately, no `done`; a new `start` after release runs normally.
